// File: rtl/bcd_addsub_serial.sv
// bcd_addsub_serial
// Digit-serial multi-digit BCD adder/subtractor. One digit slice is reused
// for every digit, LSD first. Subtraction adds the nine's complement of B
// plus one. A negative difference gets a second pass (FIX) that replaces
// the shadow result with its ten's complement, so the output is sign plus
// magnitude.
//
// Optional feature: define BCD_INPUT_CHECK_EN to check the operands for
// invalid digits (>9) when start is accepted. If any digit is invalid, err
// is set at DONE and result/carry/neg are forced to 0. When the macro is
// undefined, err is tied to 0.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   start  - operation request, accepted only while ready=1
//   op     - 0: A+B, 1: A-B (sampled with start)
//   a, b   - packed BCD operands, digit 0 in bits [3:0] (sampled with start)
//   ready  - high in IDLE
//   valid  - one-cycle pulse in DONE; result/flags are valid from then on
//   result - packed BCD result, held until the next valid
//   carry  - add overflow (A+B >= 10^DIGITS), 0 for subtract
//   neg    - subtract result negative (A < B), 0 for add
//   err    - invalid operand digit seen (BCD_INPUT_CHECK_EN only)
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                ready,
  output logic                valid,
  output logic [4*DIGITS-1:0] result,
  output logic                carry,
  output logic                neg,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [W-1:0]    result_q, result_d;
  logic            op_q, op_d, c_q, c_d;
  logic            carry_q, carry_d, neg_q, neg_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            last_digit;

  // Digit slice signals
  logic [3:0] x, y, dig;
  logic [4:0] s;
  logic       cout;

`ifdef BCD_INPUT_CHECK_EN
  logic bad_q, bad_d, err_q, err_d;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  // Shared digit slice. In CALC it adds a_i to b_i or to (9 - b_i). In FIX it
  // computes (9 - r_i) + c. The operand registers shift right, so the
  // current digit is always in bits [3:0].
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    x = a_q[3:0];
    y = op_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    if (state_q == FIX) begin
      x = 4'd9 - sh_q[3:0];
      y = 4'd0;
    end
    s    = {1'b0, x} + {1'b0, y} + {4'b0000, c_q};
    cout = (s > 5'd9);
    dig  = cout ? (s[3:0] + 4'd6) : s[3:0];
  end

  assign last_digit = (idx_q == IW'(DIGITS - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    result_d = result_q;
    op_d     = op_q;
    c_d      = c_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    idx_d    = idx_q;
`ifdef BCD_INPUT_CHECK_EN
    bad_d    = bad_q;
    err_d    = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          c_d     = op;  // the +1 of the ten's complement of B
          idx_d   = '0;
          state_d = CALC;
`ifdef BCD_INPUT_CHECK_EN
          bad_d   = has_bad_digit(a) | has_bad_digit(b);
`endif
        end
      end

      CALC: begin
        // New digits enter at the top. After DIGITS shifts, the shadow
        // register holds the whole result in normal digit order.
        sh_d  = {dig, sh_q[W-1:4]};
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        c_d   = cout;
        idx_d = idx_q + 1'b1;
        if (last_digit) begin
          if (!op_q || cout) begin
            result_d = sh_d;
            carry_d  = !op_q && cout;
            neg_d    = 1'b0;
            state_d  = DONE;
          end else begin
            // No final carry on subtract means A < B: negate the result
            idx_d   = '0;
            c_d     = 1'b1;
            state_d = FIX;
          end
        end
      end

      FIX: begin
        sh_d  = {dig, sh_q[W-1:4]};
        c_d   = cout;
        idx_d = idx_q + 1'b1;
        if (last_digit) begin
          result_d = sh_d;
          carry_d  = 1'b0;
          neg_d    = 1'b1;
          state_d  = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef BCD_INPUT_CHECK_EN
    // Applied on the edge that enters DONE, so it overrides the computed flags.
    if (state_d == DONE && state_q != DONE) begin
      err_d = bad_q;
      if (bad_q) begin
        result_d = '0;
        carry_d  = 1'b0;
        neg_d    = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register
    // samples its pre-edge value, whatever order the statements are in.
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      result_q <= '0;
      op_q     <= 1'b0;
      c_q      <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      idx_q    <= '0;
`ifdef BCD_INPUT_CHECK_EN
      bad_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      op_q     <= op_d;
      c_q      <= c_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      idx_q    <= idx_d;
`ifdef BCD_INPUT_CHECK_EN
      bad_q    <= bad_d;
      err_q    <= err_d;
`endif
    end
  end

  assign ready  = (state_q == IDLE);
  assign valid  = (state_q == DONE);
  assign result = result_q;
  assign carry  = carry_q;
  assign neg    = neg_q;
`ifdef BCD_INPUT_CHECK_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Testbench for bcd_addsub_serial with DIGITS=4. The stimulus pushes the
// expected result, flags and latency into a queue. A monitor on the falling
// edge pops an entry on every valid pulse and compares it with the DUT.
// The latency counts falling edges from the accept edge to the valid cycle.
module tb_bcd_addsub_serial;

  localparam int DIGITS = 4;

  logic                clk = 1'b0;
  logic                rst, start, op;
  logic [4*DIGITS-1:0] a, b;
  logic                ready, valid, carry, neg, err;
  logic [4*DIGITS-1:0] result;

  bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .valid(valid), .result(result),
    .carry(carry), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        n;
    logic        e;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   lat_cnt = 0;
  int   valid_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    lat_cnt++;
    if (valid === 1'b1) begin
      exp_t e;
      valid_cnt++;
      if (sb.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL unexpected_valid: got valid=1 with result=%0h, expected no valid", result);
      end else begin
        e = sb.pop_front();
        check("result",  result, e.res);
        check("carry",   carry,  e.c);
        check("neg",     neg,    e.n);
        check("err",     err,    e.e);
        check("latency", lat_cnt, e.lat);
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 50 && ready !== 1'b1; i++) @(negedge clk);
    if (ready !== 1'b1) begin
      ntests++;
      nfail++;
      $display("FAIL ready_timeout: got ready=%b expected 1", ready);
    end
  endtask

  // Issues one operation at a falling edge. The operation is accepted on the
  // next rising edge.
  task automatic issue(input logic o, input logic [15:0] av, input logic [15:0] bv);
    wait_ready();
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    lat_cnt = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      ntests++;
      nfail++;
      $display("FAIL valid_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic o, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] er, input logic ec, input logic en,
                        input logic ee, input int elat);
    exp_t e;
    issue(o, av, bv);
    e.res = er; e.c = ec; e.n = en; e.e = ee; e.lat = elat;
    sb.push_back(e);
    wait_drain();
  endtask

  initial begin
    exp_t e;
    int   vc;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready",  ready,  1'b1);
    check("rst_valid",  valid,  1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_carry",  carry,  1'b0);
    check("rst_neg",    neg,    1'b0);
    check("rst_err",    err,    1'b0);

    // Add and subtract vectors (op, a, b, result, carry, neg, err, latency)
    run_op(1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0, 5);
    run_op(1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 5);
    run_op(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5);
    run_op(1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0, 1'b0, 1'b0, 5);
    run_op(1'b1, 16'h1234, 16'h5000, 16'h3766, 1'b0, 1'b1, 1'b0, 9);
    run_op(1'b1, 16'h0042, 16'h0042, 16'h0000, 1'b0, 1'b0, 1'b0, 5);
    run_op(1'b0, 16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b0, 5);
    run_op(1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 9);

    // A start during CALC is ignored, and ready stays low until after DONE
    issue(1'b0, 16'h1111, 16'h2222);
    e.res = 16'h3333; e.c = 1'b0; e.n = 1'b0; e.e = 1'b0; e.lat = 5;
    sb.push_back(e);
    vc = valid_cnt;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("busy_ready_%0d", i), ready, 1'b0);
      if (i == 2) begin
        start = 1'b1; op = 1'b1; a = 16'h9999; b = 16'h8888;
      end
      if (i == 3) start = 1'b0;
    end
    @(negedge clk);
    check("ready_after_done", ready, 1'b1);
    check("single_valid", valid_cnt - vc, 1);
    wait_drain();

    // Reset two cycles into a negative subtract aborts it without a valid pulse
    issue(1'b1, 16'h1234, 16'h5000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    vc = valid_cnt;
    @(negedge clk);
    check("abort_ready",  ready,  1'b1);
    check("abort_valid",  valid,  1'b0);
    check("abort_result", result, 16'h0000);
    check("abort_neg",    neg,    1'b0);
    check("abort_carry",  carry,  1'b0);
    repeat (12) @(negedge clk);
    check("abort_no_valid", valid_cnt - vc, 0);
    run_op(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 5);

`ifdef BCD_INPUT_CHECK_EN
    run_op(1'b0, 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 5);
    run_op(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
